mips_mem_arbiter: RTL and testbench

Shares one Avalon-style memory master port between the CPU's instruction-fetch requester and its data load/store requester. It sits between the CPU core and the unified memory in the bus variant of the processor. Fixed priority: data wins over fetch. Each transaction is sequenced through a small FSM that tolerates `waitrequest` stalls and returns a registered response with a one-cycle `valid` pulse.

---
 rtl/mips_bus_pkg.sv | 28 ++
 rtl/mips_mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_mips_mem_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_bus_pkg.sv
// mips_bus_pkg
// Shared types and constants for the memory-bus arbiter in the bus variant
// of the MIPS core.
//   arb_state_t : arbiter sequencing states
//   arb_owner_t : which requester owns the current bus transaction
//   BE_ALL      : byte enable used for every instruction fetch
//   word_align  : clears the byte offset of a byte address
package mips_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUS    = 2'd1,
        RDWAIT = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

    localparam logic [3:0] BE_ALL = 4'b1111;

    function automatic logic [31:0] word_align(input logic [31:0] byte_addr);
        return byte_addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter
// Shares one Avalon-style memory master between the instruction-fetch
// requester (i_*) and the data load/store requester (d_*). Data has fixed
// priority over fetch. One transaction at a time is sequenced through
// IDLE -> BUS -> (RDWAIT) -> DONE -> IDLE.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   i_req, i_addr              fetch request (level) and byte address
//   i_rdata, i_valid           registered fetch data, one-cycle done pulse
//   d_read, d_write, d_addr,
//   d_wdata, d_byteen          data request (level), address, store data, byte enables
//   d_rdata, d_valid           registered load data, one-cycle done pulse
//   m_address, m_read, m_write,
//   m_writedata, m_byteenable  memory master command outputs (all from registers)
//   m_waitrequest, m_readdata  memory stall and read data (read latency 1)
//   busy                       high whenever the arbiter is not IDLE
module mips_mem_arbiter
    import mips_bus_pkg::*;
(
    input  logic        clk,
    input  logic        reset,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_valid,

    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_byteen,
    output logic [31:0] d_rdata,
    output logic        d_valid,

    output logic [31:0] m_address,
    output logic        m_read,
    output logic        m_write,
    output logic [31:0] m_writedata,
    output logic [3:0]  m_byteenable,
    input  logic        m_waitrequest,
    input  logic [31:0] m_readdata,

    output logic        busy
);

    arb_state_t  state_q,   state_d;
    arb_owner_t  owner_q,   owner_d;
    logic        write_q,   write_d;
    logic [31:0] addr_q,    addr_d;
    logic [31:0] wdata_q,   wdata_d;
    logic [3:0]  byteen_q,  byteen_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        byteen_d  = byteen_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;

        case (state_q)
            IDLE: begin
                // Data side wins; a simultaneous read+write request is a write.
                if (d_read || d_write) begin
                    owner_d  = OWN_D;
                    write_d  = d_write;
                    addr_d   = word_align(d_addr);
                    wdata_d  = d_wdata;
                    byteen_d = d_byteen;
                    state_d  = BUS;
                end else if (i_req) begin
                    owner_d  = OWN_I;
                    write_d  = 1'b0;
                    addr_d   = word_align(i_addr);
                    wdata_d  = 32'h0;
                    byteen_d = BE_ALL;
                    state_d  = BUS;
                end
            end
            BUS: begin
                // Command registers are untouched here, so the bus stays
                // stable for as long as the slave stalls.
                if (!m_waitrequest) begin
                    state_d = write_q ? DONE : RDWAIT;
                end
            end
            RDWAIT: begin
                // Slave returns read data exactly one cycle after acceptance.
                if (owner_q == OWN_D) begin
                    d_rdata_d = m_readdata;
                end else begin
                    i_rdata_d = m_readdata;
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= OWN_I;
            write_q   <= 1'b0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            byteen_q  <= 4'h0;
            i_rdata_q <= 32'h0;
            d_rdata_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            byteen_q  <= byteen_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // Everything below is decoded from registers only; no input reaches m_*.
    assign m_read       = (state_q == BUS) && !write_q;
    assign m_write      = (state_q == BUS) &&  write_q;
    assign m_address    = addr_q;
    assign m_writedata  = wdata_q;
    assign m_byteenable = byteen_q;

    assign i_valid = (state_q == DONE) && (owner_q == OWN_I);
    assign d_valid = (state_q == DONE) && (owner_q == OWN_D);
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_mips_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mips_mem_arbiter;
    import mips_bus_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_valid;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_byteen;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic [31:0] m_address;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_writedata;
    logic [3:0]  m_byteenable;
    logic        m_waitrequest;
    logic [31:0] m_readdata;
    logic        busy;

    always #5 clk = ~clk;

    mips_mem_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_rdata      (i_rdata),
        .i_valid      (i_valid),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_byteen     (d_byteen),
        .d_rdata      (d_rdata),
        .d_valid      (d_valid),
        .m_address    (m_address),
        .m_read       (m_read),
        .m_write      (m_write),
        .m_writedata  (m_writedata),
        .m_byteenable (m_byteenable),
        .m_waitrequest(m_waitrequest),
        .m_readdata   (m_readdata),
        .busy         (busy)
    );

    typedef struct {
        logic        own_d;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } bus_exp_t;

    typedef struct {
        logic        own_d;
        logic        wr;
        logic [31:0] rdata;
    } rsp_exp_t;

    typedef struct {
        logic        is_d;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          waits;
    } vec_t;

    bus_exp_t    bus_q[$];
    rsp_exp_t    rsp_q[$];
    vec_t        vecs[8];
    int          checks = 0;
    int          failures = 0;
    int          wait_left = 0;
    logic        acc_rd = 1'b0;
    logic [31:0] acc_addr = 32'h0;
    logic [31:0] model_i_rdata = 32'h0;
    logic [31:0] model_d_rdata = 32'h0;

    // Memory contents as seen by the bench.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'hBFC0_0000) return 32'h8C02_0004;
        return {a[15:0] ^ 16'hA5C3, a[31:16] ^ 16'h3C5A};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // One clock: advance, model the slave, and scoreboard bus activity and responses.
    task automatic tick();
        bus_exp_t e;
        rsp_exp_t r;
        @(posedge clk);
        #1;
        m_readdata = acc_rd ? mem_word(acc_addr) : 32'h0BAD_0BAD;
        acc_rd = 1'b0;
        if (m_read || m_write) begin
            m_waitrequest = (wait_left > 0);
            if (wait_left > 0) wait_left--;
            if (bus_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe: got addr %h required no access", m_address);
            end else begin
                e = bus_q[0];
                chk("m_read",       {31'h0, m_read},  {31'h0, !e.wr});
                chk("m_write",      {31'h0, m_write}, {31'h0, e.wr});
                chk("m_address",    m_address,        e.addr);
                chk("m_writedata",  m_writedata,      e.wdata);
                chk("m_byteenable", {28'h0, m_byteenable}, {28'h0, e.be});
                if (!m_waitrequest) begin
                    void'(bus_q.pop_front());
                    if (!e.wr) begin
                        acc_rd   = 1'b1;
                        acc_addr = e.addr;
                    end
                end
            end
        end else begin
            m_waitrequest = 1'b0;
        end
        if (i_valid || d_valid) begin
            chk("valid_overlap", {31'h0, i_valid & d_valid}, 32'h0);
            if (rsp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid: got i_valid=%0b d_valid=%0b required none", i_valid, d_valid);
            end else begin
                r = rsp_q.pop_front();
                chk("valid_owner", {31'h0, d_valid}, {31'h0, r.own_d});
                if (!r.wr) begin
                    if (r.own_d) model_d_rdata = r.rdata;
                    else         model_i_rdata = r.rdata;
                end
                chk("i_rdata", i_rdata, model_i_rdata);
                chk("d_rdata", d_rdata, model_d_rdata);
            end
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic        wr;
        logic [31:0] ea;
        int          first_strobe;
        int          lat;
        first_strobe = -1;
        lat = -1;
        wr = v.is_d && v.wr;
        ea = v.addr & 32'hFFFF_FFFC;
        bus_q.push_back(bus_exp_t'{v.is_d, wr, ea,
                                   v.is_d ? v.wdata : 32'h0,
                                   v.is_d ? v.be : 4'hF});
        rsp_q.push_back(rsp_exp_t'{v.is_d, wr, mem_word(ea)});
        wait_left = v.waits;
        i_req    = !v.is_d;
        i_addr   = v.is_d ? ~v.addr : v.addr;
        d_read   = v.is_d && v.rd;
        d_write  = v.is_d && v.wr;
        d_addr   = v.is_d ? v.addr : ~v.addr;
        d_wdata  = v.wdata;
        d_byteen = v.be;
        for (int n = 1; n <= 30; n++) begin
            tick();
            if (first_strobe < 0 && (m_read || m_write)) first_strobe = n;
            if (i_valid || d_valid) begin
                lat = n;
                break;
            end
        end
        i_req   = 1'b0;
        d_read  = 1'b0;
        d_write = 1'b0;
        chk($sformatf("v%0d_strobe_cycle", idx), first_strobe, 1);
        chk($sformatf("v%0d_latency", idx), lat, (wr ? 2 : 3) + v.waits);
        tick();
        chk($sformatf("v%0d_idle_after_done", idx), {31'h0, busy}, 32'h0);
    endtask

    initial begin
        int ds, fs, dv, iv, s1, s2, v1, v2, idle_cnt, vcount;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 32'hBFC0_0000, 32'h0000_0000, 4'h0, 0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h0000_1003, 32'h5555_5555, 4'hF, 0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 4'h3, 3};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h0000_3002, 32'h0000_0000, 4'h1, 2};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 32'h0000_0400, 32'hAAAA_AAAA, 4'h5, 1};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h0000_5001, 32'h1234_5678, 4'hC, 0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hF, 0};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 4'hF, 1};

        reset = 1'b1;
        i_req = 1'b0; i_addr = 32'h0;
        d_read = 1'b0; d_write = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_byteen = 4'h0;
        m_waitrequest = 1'b0; m_readdata = 32'h0;
        tick();
        tick();
        chk("rst_m_read",       {31'h0, m_read},  32'h0);
        chk("rst_m_write",      {31'h0, m_write}, 32'h0);
        chk("rst_m_address",    m_address,        32'h0);
        chk("rst_m_writedata",  m_writedata,      32'h0);
        chk("rst_m_byteenable", {28'h0, m_byteenable}, 32'h0);
        chk("rst_i_valid",      {31'h0, i_valid}, 32'h0);
        chk("rst_d_valid",      {31'h0, d_valid}, 32'h0);
        chk("rst_i_rdata",      i_rdata,          32'h0);
        chk("rst_d_rdata",      d_rdata,          32'h0);
        chk("rst_busy",         {31'h0, busy},    32'h0);
        reset = 1'b0;
        tick();

        for (int k = 0; k < 8; k++) begin
            run_vec(k, vecs[k]);
        end

        // Contention: data and fetch raised together, data served first.
        bus_q.push_back(bus_exp_t'{1'b1, 1'b0, 32'h0000_1000, 32'h1111_1111, 4'hF});
        bus_q.push_back(bus_exp_t'{1'b0, 1'b0, 32'h0000_8000, 32'h0, 4'hF});
        rsp_q.push_back(rsp_exp_t'{1'b1, 1'b0, mem_word(32'h0000_1000)});
        rsp_q.push_back(rsp_exp_t'{1'b0, 1'b0, mem_word(32'h0000_8000)});
        wait_left = 0;
        ds = -1; fs = -1; dv = -1; iv = -1;
        i_req = 1'b1; i_addr = 32'h0000_8000;
        d_read = 1'b1; d_addr = 32'h0000_1003; d_wdata = 32'h1111_1111; d_byteen = 4'hF;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (ds < 0 && m_read && m_address == 32'h0000_1000) ds = n;
            if (fs < 0 && m_read && m_address == 32'h0000_8000) fs = n;
            if (d_valid) begin
                dv = n;
                d_read = 1'b0;
            end
            if (i_valid) begin
                iv = n;
                i_req = 1'b0;
                break;
            end
        end
        i_req = 1'b0; d_read = 1'b0;
        chk("cont_data_strobe", ds, 1);
        chk("cont_fetch_gap", fs - ds, 4);
        chk("cont_d_valid_cycle", dv, 3);
        chk("cont_i_valid_cycle", iv, 7);
        tick();

        // Reset while the slave is stalling a write.
        bus_q.push_back(bus_exp_t'{1'b1, 1'b1, 32'h0000_2000, 32'hCAFE_F00D, 4'hF});
        wait_left = 50;
        d_write = 1'b1; d_addr = 32'h0000_2000; d_wdata = 32'hCAFE_F00D; d_byteen = 4'hF;
        tick();
        chk("rstmid_strobe_before", {31'h0, m_write}, 32'h1);
        chk("rstmid_busy_before",   {31'h0, busy},    32'h1);
        d_write = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("rstmid_m_write", {31'h0, m_write}, 32'h0);
        chk("rstmid_m_read",  {31'h0, m_read},  32'h0);
        chk("rstmid_busy",    {31'h0, busy},    32'h0);
        chk("rstmid_d_valid", {31'h0, d_valid}, 32'h0);
        chk("rstmid_address", m_address,        32'h0);
        chk("rstmid_d_rdata", d_rdata,          32'h0);
        reset = 1'b0;
        bus_q.delete();
        wait_left = 0;
        model_i_rdata = 32'h0;
        model_d_rdata = 32'h0;
        repeat (3) tick();
        run_vec(8, vecs[0]);

        // Held fetch request: two back-to-back fetches, one IDLE between.
        bus_q.push_back(bus_exp_t'{1'b0, 1'b0, 32'h0000_0104, 32'h0, 4'hF});
        bus_q.push_back(bus_exp_t'{1'b0, 1'b0, 32'h0000_0104, 32'h0, 4'hF});
        rsp_q.push_back(rsp_exp_t'{1'b0, 1'b0, mem_word(32'h0000_0104)});
        rsp_q.push_back(rsp_exp_t'{1'b0, 1'b0, mem_word(32'h0000_0104)});
        wait_left = 0;
        s1 = -1; s2 = -1; v1 = -1; v2 = -1; idle_cnt = 0; vcount = 0;
        i_req = 1'b1; i_addr = 32'h0000_0104;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (m_read) begin
                if (s1 < 0) s1 = n;
                else if (s2 < 0) s2 = n;
            end
            if (!busy) idle_cnt++;
            if (i_valid) begin
                vcount++;
                if (vcount == 1) v1 = n;
                else begin
                    v2 = n;
                    i_req = 1'b0;
                    break;
                end
            end
        end
        i_req = 1'b0;
        chk("held_idle_cycles", idle_cnt, 1);
        chk("held_strobe_gap", s2 - s1, 4);
        chk("held_valid_gap", v2 - v1, 4);
        tick();
        chk("held_idle_after", {31'h0, busy}, 32'h0);
        repeat (2) tick();
        chk("scoreboard_bus_drained", bus_q.size(), 0);
        chk("scoreboard_rsp_drained", rsp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
